// File: rtl/frac_block_feeder.sv
// frac_block_feeder
//   Transmit side of the fractional-MV search row interface. Buffers one 8x8
//   filter block and one 8x8 reference block, streams them as 8 contiguous
//   row pairs, then samples the returned fractional MV after RESULT_LAT cycles.
//
//   Optional feature macro: FEEDER_STALL_EN (adds the 'stall' input).
//
// Ports
//   clk, reset            clock (rising edge), async active-low reset
//   wr_en/wr_sel/wr_row/wr_data   row write port (IDLE only); sel 0=filter, 1=ref
//   start                 request to stream the buffered pair
//   stall                 (FEEDER_STALL_EN only) pause streaming while high
//   filter_pix, ref_pix   row pair, valid while input_ready=1
//   input_ready           row pair valid
//   mv_in_x, mv_in_y      returned fractional MV
//   mvx, mvy, done        latched MV and its one-cycle update pulse
//   busy, loaded          not idle / all 16 rows written since last stream
//   start_err             one-cycle pulse when a start is rejected
module frac_block_feeder #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned PIX_W      = 64,
    parameter int unsigned RESULT_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [2:0]       wr_row,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             start,
`ifdef FEEDER_STALL_EN
    input  logic             stall,
`endif
    output logic [PIX_W-1:0] filter_pix,
    output logic [PIX_W-1:0] ref_pix,
    output logic             input_ready,
    input  logic [2:0]       mv_in_x,
    input  logic [2:0]       mv_in_y,
    output logic [2:0]       mvx,
    output logic [2:0]       mvy,
    output logic             done,
    output logic             busy,
    output logic             loaded,
    output logic             start_err
);

    localparam int unsigned ROW_W  = 3;
    localparam int unsigned MASK_W = 16;
    localparam int unsigned WAIT_W = 4;
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RESULT_LAT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                ir_q, ir_d;
    logic [PIX_W-1:0]    fpix_q, fpix_d;
    logic [PIX_W-1:0]    rpix_q, rpix_d;
    logic [2:0]          mvx_q, mvx_d;
    logic [2:0]          mvy_q, mvy_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                loaded_q, loaded_d;
    logic                serr_q, serr_d;

    logic [PIX_W-1:0]    filt_mem_q [ROWS];
    logic [PIX_W-1:0]    ref_mem_q  [ROWS];

    logic                wr_ok_c;
    logic                stall_c;

    assign wr_ok_c = wr_en && (state_q == ST_IDLE);

`ifdef FEEDER_STALL_EN
    assign stall_c = stall;
`else
    assign stall_c = 1'b0;
`endif

    // Row buffers: written in IDLE only, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            if (wr_sel) begin
                ref_mem_q[wr_row] <= wr_data;
            end else begin
                filt_mem_q[wr_row] <= wr_data;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        row_d    = row_q;
        wait_d   = wait_q;
        ir_d     = 1'b0;
        fpix_d   = '0;
        rpix_d   = '0;
        mvx_d    = mvx_q;
        mvy_d    = mvy_q;
        done_d   = 1'b0;
        serr_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_ok_c) begin
                    mask_d[{wr_sel, wr_row}] = 1'b1;
                end
                // start is judged against the mask before any same-cycle write
                if (start) begin
                    if (&mask_q) begin
                        state_d = ST_SEND;
                        row_d   = '0;
                        ir_d    = 1'b1;
                        fpix_d  = filt_mem_q[0];
                        rpix_d  = ref_mem_q[0];
                    end else begin
                        serr_d  = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                if (stall_c) begin
                    // row_q was already presented; hold buses until resumed
                    fpix_d = fpix_q;
                    rpix_d = rpix_q;
                end else if (row_q == LAST_ROW) begin
                    state_d = ST_WAIT;
                    row_d   = '0;
                    mask_d  = '0;
                    wait_d  = WAIT_INIT;
                end else begin
                    row_d  = row_q + ROW_W'(1);
                    ir_d   = 1'b1;
                    fpix_d = filt_mem_q[row_d];
                    rpix_d = ref_mem_q[row_d];
                end
            end

            ST_WAIT: begin
                // <= 1 also covers an out-of-range RESULT_LAT of 0
                if (wait_q <= WAIT_W'(1)) begin
                    mvx_d   = mv_in_x;
                    mvy_d   = mv_in_y;
                    done_d  = 1'b1;
                    wait_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    wait_d  = wait_q - WAIT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d   = (state_d != ST_IDLE);
        loaded_d = &mask_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            row_q    <= '0;
            wait_q   <= '0;
            ir_q     <= 1'b0;
            fpix_q   <= '0;
            rpix_q   <= '0;
            mvx_q    <= '0;
            mvy_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            loaded_q <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            row_q    <= row_d;
            wait_q   <= wait_d;
            ir_q     <= ir_d;
            fpix_q   <= fpix_d;
            rpix_q   <= rpix_d;
            mvx_q    <= mvx_d;
            mvy_q    <= mvy_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            loaded_q <= loaded_d;
            serr_q   <= serr_d;
        end
    end

    assign filter_pix  = fpix_q;
    assign ref_pix     = rpix_q;
    assign input_ready = ir_q;
    assign mvx         = mvx_q;
    assign mvy         = mvy_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign loaded      = loaded_q;
    assign start_err   = serr_q;

endmodule

// File: tb/tb_frac_block_feeder.sv
// Bench for frac_block_feeder (default build, RESULT_LAT=1).
module tb_frac_block_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [2:0]  wr_row = '0;
    logic [63:0] wr_data = '0;
    logic        start = 1'b0;
    logic [2:0]  mv_in_x = '0;
    logic [2:0]  mv_in_y = '0;
    logic [63:0] filter_pix, ref_pix;
    logic        input_ready;
    logic [2:0]  mvx, mvy;
    logic        done, busy, loaded, start_err;

    frac_block_feeder #(.ROWS(8), .PIX_W(64), .RESULT_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_data(wr_data),
        .start(start),
        .filter_pix(filter_pix), .ref_pix(ref_pix), .input_ready(input_ready),
        .mv_in_x(mv_in_x), .mv_in_y(mv_in_y),
        .mvx(mvx), .mvy(mvy), .done(done),
        .busy(busy), .loaded(loaded), .start_err(start_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int rows_seen = 0;

    logic [63:0] mf [8];
    logic [63:0] mr [8];
    logic [63:0] exp_f_q [$];
    logic [63:0] exp_r_q [$];
    logic [5:0]  exp_mv_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Write one row and mirror it into the reference model
    task automatic wr(input logic sel, input logic [2:0] row, input logic [63:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_row = row; wr_data = d;
        tick();
        wr_en = 1'b0;
        if (sel) mr[row] = d; else mf[row] = d;
    endtask

    task automatic push_burst(input logic [5:0] mv);
        for (int r = 0; r < 8; r++) begin
            exp_f_q.push_back(mf[r]);
            exp_r_q.push_back(mr[r]);
        end
        exp_mv_q.push_back(mv);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called at negedge number k0 after the accepting edge; mv_in is only
    // correct during the cycle before the expected done
    task automatic wait_done(input logic [2:0] mx, input logic [2:0] my,
                             input int exp_lat, input int k0);
        int k;
        k = k0;
        mv_in_x = ~mx; mv_in_y = ~my;
        while (!done && k < 40) begin
            if (k == exp_lat - 1) begin
                mv_in_x = mx; mv_in_y = my;
            end
            tick();
            k++;
        end
        chk("done_latency", 64'(k), 64'(exp_lat));
        tick();
        mv_in_x = ~mx; mv_in_y = ~my;
        chk("done_one_cycle", 64'(done), 64'd0);
        tick();
        chk("mvx_hold", 64'(mvx), 64'(mx));
        chk("mvy_hold", 64'(mvy), 64'(my));
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    // Scoreboard: every valid row and every done is matched against the queues
    always @(negedge clk) begin
        logic [63:0] ef, er;
        logic [5:0]  em;
        if (reset) begin
            if (input_ready) begin
                rows_seen++;
                if (exp_f_q.size() == 0) begin
                    chk("unexpected_row", 64'(exp_f_q.size()), 64'd1);
                end else begin
                    ef = exp_f_q.pop_front();
                    er = exp_r_q.pop_front();
                    chk("filter_pix", filter_pix, ef);
                    chk("ref_pix", ref_pix, er);
                end
            end else begin
                chk("filter_pix_idle", filter_pix, 64'd0);
                chk("ref_pix_idle", ref_pix, 64'd0);
            end
            if (done) begin
                if (exp_mv_q.size() == 0) begin
                    chk("unexpected_done", 64'(exp_mv_q.size()), 64'd1);
                end else begin
                    em = exp_mv_q.pop_front();
                    chk("mv_result", 64'({mvx, mvy}), 64'(em));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic load_pattern(input int seed_mode);
        logic [63:0] d;
        for (int r = 0; r < 8; r++) begin
            if (seed_mode == 0) d = 64'h0101010101010101 * 64'(r + 1);
            else d = {$urandom, $urandom};
            wr(1'b0, 3'(r), d);
            wr(1'b1, 3'(r), ~d);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_input_ready", 64'(input_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_loaded", 64'(loaded), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_start_err", 64'(start_err), 64'd0);
        chk("rst_mv", 64'({mvx, mvy}), 64'd0);
        reset = 1'b1;
        tick();

        // Basic burst with the ramp pattern
        load_pattern(0);
        chk("loaded_full", 64'(loaded), 64'd1);
        push_burst({3'd5, 3'd2});
        pulse_start();
        chk("busy_send", 64'(busy), 64'd1);
        chk("ir_first_cycle", 64'(input_ready), 64'd1);
        wait_done(3'd5, 3'd2, 10, 1);
        chk("loaded_cleared", 64'(loaded), 64'd0);
        chk("rows_burst1", 64'(rows_seen), 64'd8);

        // 15 of 16 rows written: start rejected
        for (int i = 0; i < 15; i++) begin
            wr(1'(i >> 3), 3'(i), {$urandom, $urandom});
        end
        chk("loaded_15", 64'(loaded), 64'd0);
        pulse_start();
        chk("start_err_pulse", 64'(start_err), 64'd1);
        chk("busy_rejected", 64'(busy), 64'd0);
        tick();
        chk("start_err_clear", 64'(start_err), 64'd0);
        chk("ir_rejected", 64'(input_ready), 64'd0);

        // Last write together with start: start sees the old mask, write lands
        start = 1'b1;
        wr(1'b1, 3'd7, {$urandom, $urandom});
        start = 1'b0;
        chk("start_err_same_cycle", 64'(start_err), 64'd1);
        chk("loaded_after_same_cycle", 64'(loaded), 64'd1);

        // Start and writes during SEND are ignored
        push_burst({3'd3, 3'd6});
        pulse_start();
        tick();
        tick();
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_row = 3'd2;
        wr_data = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        start = 1'b0; wr_en = 1'b0;
        chk("no_start_err_in_send", 64'(start_err), 64'd0);
        wait_done(3'd3, 3'd6, 10, 4);
        chk("loaded_after_send_write", 64'(loaded), 64'd0);
        chk("rows_burst2", 64'(rows_seen), 64'd16);

        // Mask was cleared: a single row is not enough
        wr(1'b0, 3'd0, 64'h1234);
        pulse_start();
        chk("start_err_after_clear", 64'(start_err), 64'd1);

        // Reset in the middle of a burst
        load_pattern(1);
        push_burst({3'd7, 3'd7});
        pulse_start();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("async_ir_drop", 64'(input_ready), 64'd0);
        chk("async_busy_drop", 64'(busy), 64'd0);
        chk("async_loaded_drop", 64'(loaded), 64'd0);
        chk("async_pix_drop", filter_pix, 64'd0);
        exp_f_q.delete();
        exp_r_q.delete();
        exp_mv_q.delete();
        repeat (3) begin
            tick();
            chk("no_done_in_reset", 64'(done), 64'd0);
        end
        reset = 1'b1;
        repeat (12) begin
            tick();
            chk("no_done_after_abort", 64'(done), 64'd0);
        end
        chk("loaded_after_abort", 64'(loaded), 64'd0);

        // Recovery burst with random data
        load_pattern(1);
        push_burst({3'd6, 3'd1});
        pulse_start();
        wait_done(3'd6, 3'd1, 10, 1);
        chk("rows_left", 64'(exp_f_q.size()), 64'd0);
        chk("mv_left", 64'(exp_mv_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
